dm_load_unit: RTL and testbench

DM_LOAD_UNIT -- requirements
Module: dm_load_unit

---
 rtl/dm_load_unit_pkg.sv | 27 ++
 rtl/dm_load_unit_ld_align_ext.sv | 29 ++
 rtl/dm_load_unit.sv | 114 +++++++++++
 tb/tb_dm_load_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dm_load_unit_pkg.sv
// Shared memory-op encodings and load-unit FSM state type.
package dm_load_unit_pkg;

  typedef enum logic [1:0] {
    MEMOP_BYTE = 2'b00,
    MEMOP_HALF = 2'b01,
    MEMOP_WORD = 2'b10,
    MEMOP_RSVD = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } ld_state_e;

  // Reserved op or an access not aligned to its own size.
  function automatic logic ld_illegal(input logic [1:0] op, input logic [1:0] a);
    case (op)
      MEMOP_BYTE: ld_illegal = 1'b0;
      MEMOP_HALF: ld_illegal = a[0];
      MEMOP_WORD: ld_illegal = (a != 2'b00);
      default:    ld_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_unit_ld_align_ext.sv
// Lane select and sign/zero extension of a memory word for byte/half/word loads.
module ld_align_ext
  import dm_load_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  mem_op_e     op,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    half_v = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (op)
      MEMOP_BYTE: data = {{24{~uns & byte_v[7]}}, byte_v};
      MEMOP_HALF: data = {{16{~uns & half_v[15]}}, half_v};
      default:    data = word;
    endcase
  end
endmodule

// File: rtl/dm_load_unit.sv
// Data-memory load unit: one outstanding load, fixed read latency, held response.
module dm_load_unit
  import dm_load_unit_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_op,
  input  logic              ld_unsigned,
  output logic              ld_ready,
  output logic              ld_valid,
  input  logic              ld_ack,
  output logic [31:0]       ld_data,
  output logic              ld_err,
  output logic              mem_rd,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata
);
  localparam logic [2:0] LAT = 3'(RD_LAT);

  ld_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        a_q, a_d;
  mem_op_e           op_q, op_d;
  logic              uns_q, uns_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic              illegal, accept;
  logic [31:0]       fmt;

  ld_align_ext u_align (
    .word (mem_rdata),
    .addr (a_q),
    .op   (op_q),
    .uns  (uns_q),
    .data (fmt)
  );

  // rstn gates acceptance so no strobe escapes while reset is asserted.
  assign illegal = ld_illegal(ld_op, ld_addr[1:0]);
  assign accept  = (state_q == ST_IDLE) && ld_req && rstn && !illegal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    op_d    = op_q;
    uns_d   = uns_q;
    data_d  = data_q;
    err_d   = err_q;
    maddr_d = maddr_q;
    case (state_q)
      ST_IDLE: if (ld_req && rstn) begin
        data_d = 32'h0;
        if (illegal) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          err_d   = 1'b0;
          a_d     = ld_addr[1:0];
          op_d    = mem_op_e'(ld_op);
          uns_d   = ld_unsigned;
          cnt_d   = LAT;
          maddr_d = ld_addr[ADDR_W-1:2];
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Count of 1 marks the cycle mem_rdata is valid.
        if (cnt_q == 3'd1) begin
          data_d  = fmt;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (ld_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      a_q     <= 2'b00;
      op_q    <= MEMOP_BYTE;
      uns_q   <= 1'b0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      op_q    <= op_d;
      uns_q   <= uns_d;
      data_q  <= data_d;
      err_q   <= err_d;
      maddr_q <= maddr_d;
    end
  end

  assign ld_ready = (state_q == ST_IDLE);
  assign ld_valid = (state_q == ST_RESP);
  assign ld_data  = data_q;
  assign ld_err   = err_q;
  assign mem_rd   = accept;
  assign mem_addr = accept ? ld_addr[ADDR_W-1:2] : maddr_q;
endmodule

// File: tb/tb_dm_load_unit.sv
// Randomized bench for dm_load_unit against a shift/mask reference model.
module tb_dm_load_unit;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              ld_req = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [1:0]        ld_op = 2'b00;
  logic              ld_unsigned = 1'b0;
  logic              ld_ready, ld_valid, ld_err, mem_rd;
  logic              ld_ack = 1'b0;
  logic [31:0]       ld_data, mem_rdata;
  logic [ADDR_W-3:0] mem_addr;

  int n_cmp = 0;
  int n_mis = 0;
  int rd_cnt = 0;

  logic [31:0]       mem [128];
  logic [RD_LAT-1:0] pv = '0;
  logic [6:0]        pa [RD_LAT];

  dm_load_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .ld_req(ld_req), .ld_addr(ld_addr), .ld_op(ld_op),
    .ld_unsigned(ld_unsigned), .ld_ready(ld_ready), .ld_valid(ld_valid),
    .ld_ack(ld_ack), .ld_data(ld_data), .ld_err(ld_err), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    pv <= {pv[RD_LAT-2:0], mem_rd};
    pa[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
    if (mem_rd) rd_cnt <= rd_cnt + 1;
  end
  assign mem_rdata = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {err, data} from the load rules using plain shifts and masks.
  function automatic logic [32:0] model(input logic [31:0] w, input logic [8:0] a,
                                        input logic [1:0] op, input logic u);
    int unsigned v;
    if (op == 2'd3 || (op == 2'd1 && a[0]) || (op == 2'd2 && a[1:0] != 2'd0))
      return {1'b1, 32'h0};
    v = w >> (8 * a[1:0]);
    if (op == 2'd0) begin
      v = v & 32'hFF;
      if (!u && v >= 128) v = v + 32'hFFFFFF00;
    end else if (op == 2'd1) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32768) v = v + 32'hFFFF0000;
    end
    return {1'b0, v};
  endfunction

  task automatic do_load(input logic [8:0] a, input logic [1:0] op, input logic u, input int hold);
    logic [32:0] e;
    logic        legal;
    logic [31:0] d0;
    int          n, rd0;
    e = model(mem[a[8:2]], a, op, u);
    legal = !e[32];
    chk("ready_idle", ld_ready, 1);
    rd0 = rd_cnt;
    ld_req = 1; ld_addr = a; ld_op = op; ld_unsigned = u; ld_ack = 0;
    #1;
    chk("mem_rd_accept", mem_rd, legal);
    if (legal) chk("mem_addr", mem_addr, a[8:2]);
    step();
    n = 1;
    while (!ld_valid && n < 20) begin
      ld_req = 1'($urandom); ld_addr = 9'($urandom); ld_op = 2'($urandom); ld_ack = 1'($urandom);
      #1;
      chk("rd_in_wait", mem_rd, 0);
      step();
      n++;
    end
    ld_ack = 0;
    chk("latency", n, legal ? RD_LAT + 1 : 1);
    chk("data", ld_data, e[31:0]);
    chk("err", ld_err, e[32]);
    d0 = ld_data;
    repeat (hold) begin
      ld_req = 1'($urandom); ld_addr = 9'($urandom); ld_op = 2'($urandom);
      #1;
      chk("ready_resp", ld_ready, 0);
      chk("rd_resp", mem_rd, 0);
      step();
      chk("hold_data", ld_data, d0);
      chk("hold_valid", ld_valid, 1);
    end
    ld_req = 0; ld_ack = 1;
    step();
    ld_ack = 0;
    chk("valid_after_ack", ld_valid, 0);
    chk("ready_after_ack", ld_ready, 1);
    chk("rd_count", rd_cnt - rd0, legal ? 1 : 0);
  endtask

  initial begin
    int rd0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[5] = 32'h8899AABB;

    #1;
    chk("rst_ready", ld_ready, 1);
    chk("rst_valid", ld_valid, 0);
    chk("rst_data", ld_data, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    step(); step();
    rstn = 1;
    step();

    do_load(9'h014, 2'b10, 1'b0, 0);
    do_load(9'h017, 2'b00, 1'b0, 1);
    do_load(9'h017, 2'b00, 1'b1, 0);
    do_load(9'h014, 2'b00, 1'b0, 0);
    do_load(9'h016, 2'b01, 1'b0, 2);
    do_load(9'h014, 2'b01, 1'b1, 0);
    do_load(9'h015, 2'b10, 1'b0, 0);
    do_load(9'h014, 2'b11, 1'b0, 0);
    do_load(9'h014, 2'b10, 1'b1, 5);

    for (int k = 0; k < 60; k++)
      do_load(9'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Reset while waiting on memory; the late read data must be dropped.
    rd0 = rd_cnt;
    ld_req = 1; ld_addr = 9'h014; ld_op = 2'b10; ld_unsigned = 0;
    step();
    ld_req = 0;
    #2;
    rstn = 0;
    #1;
    chk("wrst_ready", ld_ready, 1);
    chk("wrst_valid", ld_valid, 0);
    chk("wrst_data", ld_data, 0);
    chk("wrst_err", ld_err, 0);
    chk("wrst_mem_rd", mem_rd, 0);
    chk("wrst_mem_addr", mem_addr, 0);
    step();
    rstn = 1;
    repeat (6) begin
      step();
      chk("late_valid", ld_valid, 0);
      chk("late_ready", ld_ready, 1);
    end
    chk("wrst_rd_count", rd_cnt - rd0, 1);
    do_load(9'h016, 2'b01, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
